// File: rtl/diverge_ctrl.sv
// diverge_ctrl: control FSM for SIMD branch divergence.
// Decodes IF / ELSE / ENDIF, drives push / complement / pop commands to an
// external mask stack, tracks nesting depth and requests a fetch redirect
// when the stack reports that no lane is left active on a taken path.
module diverge_ctrl #(
    parameter int N_CORES    = 4,
    parameter int DEPTH_BITS = 3,
    parameter int PC_W       = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [1:0]            instr_op,
    input  logic [N_CORES-1:0]    cond,
    input  logic [PC_W-1:0]       target_pc,
    input  logic [N_CORES-1:0]    tos,
    input  logic                  all_false,
    output logic                  stk_push,
    output logic                  stk_pop,
    output logic                  stk_comp,
    output logic [N_CORES-1:0]    stk_d_in,
    output logic                  redirect_valid,
    output logic [PC_W-1:0]       redirect_pc,
    output logic                  instr_done,
    output logic [DEPTH_BITS-1:0] depth,
    output logic                  err_overflow,
    output logic                  err_underflow
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EVAL   = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_IF    = 2'b01;
    localparam logic [1:0] OP_ELSE  = 2'b10;
    localparam logic [1:0] OP_ENDIF = 2'b11;

    localparam logic [DEPTH_BITS-1:0] DEPTH_MAX  = '1;
    localparam logic [DEPTH_BITS-1:0] DEPTH_ZERO = '0;
    localparam logic [DEPTH_BITS-1:0] DEPTH_ONE  = DEPTH_BITS'(1);

    state_t                state_q, state_d;
    logic [1:0]            op_q, op_d;
    logic [N_CORES-1:0]    cond_q, cond_d;
    logic [PC_W-1:0]       tgt_q, tgt_d;
    logic [DEPTH_BITS-1:0] depth_q, depth_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    // Registered command / status outputs, decided one edge ahead.
    logic                  push_q, push_d;
    logic                  pop_q, pop_d;
    logic                  comp_q, comp_d;
    logic                  done_q, done_d;
    logic                  ready_q, ready_d;
    // Set in SETTLE when the evaluated IF/ELSE actually touched the stack;
    // only then may an all_false report turn into a redirect.
    logic                  redir_en_q, redir_en_d;

    // Next-state logic: the stack command is chosen at the accept edge from
    // the incoming op and the current depth, so it is a clean flop in EVAL.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cond_d     = cond_q;
        tgt_d      = tgt_q;
        depth_d    = depth_q;
        ovf_d      = ovf_q;
        udf_d      = udf_q;
        push_d     = 1'b0;
        pop_d      = 1'b0;
        comp_d     = 1'b0;
        done_d     = 1'b0;
        ready_d    = 1'b0;
        redir_en_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (instr_valid) begin
                    op_d    = instr_op;
                    cond_d  = cond;
                    tgt_d   = target_pc;
                    state_d = ST_EVAL;
                    ready_d = 1'b0;
                    unique case (instr_op)
                        OP_IF:    push_d = (depth_q != DEPTH_MAX);
                        OP_ELSE:  comp_d = (depth_q != DEPTH_ZERO);
                        OP_ENDIF: pop_d  = (depth_q != DEPTH_ZERO);
                        default:  ;
                    endcase
                end
            end
            ST_EVAL: begin
                state_d    = ST_SETTLE;
                done_d     = 1'b1;
                redir_en_d = push_q | comp_q;
                if (push_q) begin
                    depth_d = depth_q + DEPTH_ONE;
                end
                if (pop_q) begin
                    depth_d = depth_q - DEPTH_ONE;
                end
                if ((op_q == OP_IF) && !push_q) begin
                    ovf_d = 1'b1;
                end
                if (((op_q == OP_ELSE) && !comp_q) || ((op_q == OP_ENDIF) && !pop_q)) begin
                    udf_d = 1'b1;
                end
            end
            ST_SETTLE: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers; reset aborts any in-flight instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_NOP;
            cond_q     <= '0;
            tgt_q      <= '0;
            depth_q    <= '0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            push_q     <= 1'b0;
            pop_q      <= 1'b0;
            comp_q     <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b1;
            redir_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            cond_q     <= cond_d;
            tgt_q      <= tgt_d;
            depth_q    <= depth_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
            push_q     <= push_d;
            pop_q      <= pop_d;
            comp_q     <= comp_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
            redir_en_q <= redir_en_d;
        end
    end

    // Pushed mask is the live top-of-stack narrowed by the latched predicate;
    // gating with push keeps the bus at zero whenever no push is issued.
    generate
        for (genvar gi = 0; gi < N_CORES; gi++) begin : g_lane
            assign stk_d_in[gi] = push_q & cond_q[gi] & tos[gi];
        end
    endgenerate

    assign instr_ready    = ready_q;
    assign stk_push       = push_q;
    assign stk_pop        = pop_q;
    assign stk_comp       = comp_q;
    assign instr_done     = done_q;
    assign redirect_valid = redir_en_q & all_false;
    assign redirect_pc    = tgt_q;
    assign depth          = depth_q;
    assign err_overflow   = ovf_q;
    assign err_underflow  = udf_q;

endmodule

// File: tb/tb_diverge_ctrl.sv
// tb_diverge_ctrl: scenario tasks drive branch instructions; a behavioural
// model pushes the expected per-instruction outcome into a queue and a
// monitor pops and compares it whenever the DUT pulses instr_done.
module tb_diverge_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [1:0] instr_op = 2'b00;
    logic [3:0] cond = 4'b0000;
    logic [7:0] target_pc = 8'h00;
    logic [3:0] tos = 4'b0000;
    logic       all_false = 1'b0;
    logic       stk_push, stk_pop, stk_comp;
    logic [3:0] stk_d_in;
    logic       redirect_valid;
    logic [7:0] redirect_pc;
    logic       instr_done;
    logic [2:0] depth;
    logic       err_overflow, err_underflow;

    diverge_ctrl #(.N_CORES(4), .DEPTH_BITS(3), .PC_W(8)) dut (
        .clk(clk), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .cond(cond), .target_pc(target_pc),
        .tos(tos), .all_false(all_false),
        .stk_push(stk_push), .stk_pop(stk_pop), .stk_comp(stk_comp),
        .stk_d_in(stk_d_in),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_done(instr_done), .depth(depth),
        .err_overflow(err_overflow), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       push;
        logic       pop;
        logic       comp;
        logic [3:0] d_in;
        logic       redir;
        logic [7:0] rpc;
        logic [2:0] depth;
        logic       ovf;
        logic       udf;
    } rec_t;

    rec_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_depth = 0;
    logic m_ovf   = 1'b0;
    logic m_udf   = 1'b0;

    // Expected outcome of one instruction; updates the model state.
    function automatic rec_t model_step(input logic [1:0] op, input logic [3:0] c,
                                        input logic [7:0] tgt, input logic [3:0] t,
                                        input logic af);
        rec_t r;
        r = '0;
        r.rpc = tgt;
        case (op)
            2'b01: if (m_depth < 7) begin
                       r.push = 1'b1; r.d_in = c & t; r.redir = af; m_depth++;
                   end else m_ovf = 1'b1;
            2'b10: if (m_depth > 0) begin
                       r.comp = 1'b1; r.redir = af;
                   end else m_udf = 1'b1;
            2'b11: if (m_depth > 0) begin
                       r.pop = 1'b1; m_depth--;
                   end else m_udf = 1'b1;
            default: ;
        endcase
        r.depth = 3'(m_depth);
        r.ovf   = m_ovf;
        r.udf   = m_udf;
        return r;
    endfunction

    // Monitor: per-cycle command invariants plus scoreboard compare on done.
    task automatic scoreboard_monitor();
        logic       p_push = 1'b0, p_pop = 1'b0, p_comp = 1'b0;
        logic [3:0] p_d_in = 4'b0000;
        rec_t o, e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                n_tests++;
                if ($countones({stk_push, stk_pop, stk_comp}) > 1) begin
                    n_fail++;
                    $display("FAIL one_cmd got push/pop/comp=%b%b%b want at most one", stk_push, stk_pop, stk_comp);
                end
                n_tests++;
                if (!stk_push && stk_d_in !== 4'b0000) begin
                    n_fail++;
                    $display("FAIL d_in_idle got %b want 0000", stk_d_in);
                end
                if (instr_done) begin
                    o = {p_push, p_pop, p_comp, p_d_in, redirect_valid, redirect_pc,
                         depth, err_overflow, err_underflow};
                    n_tests++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_done got record %h want no done", o);
                    end else begin
                        e = exp_q.pop_front();
                        if (o !== e) begin
                            n_fail++;
                            $display("FAIL scoreboard got %h want %h (push pop comp d_in redir rpc depth ovf udf)", o, e);
                        end else begin
                            $display("[TB] txn ok: %h", o);
                        end
                    end
                end
            end
            p_push = stk_push; p_pop = stk_pop; p_comp = stk_comp; p_d_in = stk_d_in;
        end
    endtask

    task automatic model_clear();
        m_depth = 0; m_ovf = 1'b0; m_udf = 1'b0;
        exp_q.delete();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1; instr_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    // Drive one instruction at the first IDLE cycle; tos/all_false held after.
    task automatic issue(input logic [1:0] op, input logic [3:0] c, input logic [7:0] tgt,
                         input logic [3:0] t, input logic af);
        int waited = 0;
        @(negedge clk);
        while (!instr_ready && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        if (!instr_ready) begin
            n_tests++; n_fail++;
            $display("FAIL issue_timeout got instr_ready=0 want 1 within 10 cycles");
            return;
        end
        instr_valid = 1'b1; instr_op = op; cond = c; target_pc = tgt; tos = t; all_false = af;
        exp_q.push_back(model_step(op, c, tgt, t, af));
        @(negedge clk);
        instr_valid = 1'b0; cond = 4'b0000;
    endtask

    task automatic flush(input string name);
        repeat (4) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_pending got %0d undone want 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; instr_valid = 1'b1; instr_op = 2'b01; cond = 4'b1111; tos = 4'b1111;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0; instr_valid = 1'b0;
        model_clear();
        n_tests++;
        if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", instr_ready); end
        n_tests++;
        if ({stk_push, stk_pop, stk_comp, stk_d_in} !== 7'b0) begin
            n_fail++; $display("FAIL reset_cmds got %b want 0000000", {stk_push, stk_pop, stk_comp, stk_d_in});
        end
        n_tests++;
        if ({redirect_valid, instr_done} !== 2'b00) begin
            n_fail++; $display("FAIL reset_pulses got %b want 00", {redirect_valid, instr_done});
        end
        n_tests++;
        if ({depth, err_overflow, err_underflow} !== 5'b0) begin
            n_fail++; $display("FAIL reset_state got %b want 00000", {depth, err_overflow, err_underflow});
        end
        @(negedge clk);
        n_tests++;
        if (stk_push !== 1'b0 || instr_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_dominates got push=%b ready=%b want 0 1", stk_push, instr_ready);
        end
    endtask

    task automatic test_if_basic();
        apply_reset();
        @(negedge clk);
        instr_valid = 1'b1; instr_op = 2'b01; cond = 4'b0101; tos = 4'b1111;
        target_pc = 8'h10; all_false = 1'b0;
        exp_q.push_back(model_step(2'b01, 4'b0101, 8'h10, 4'b1111, 1'b0));
        @(posedge clk); #1;
        instr_valid = 1'b0;
        n_tests++;
        if (stk_push !== 1'b1 || stk_d_in !== 4'b0101 || instr_ready !== 1'b0) begin
            n_fail++; $display("FAIL if_eval got push=%b d_in=%b ready=%b want 1 0101 0", stk_push, stk_d_in, instr_ready);
        end
        @(posedge clk); #1;
        n_tests++;
        if (instr_done !== 1'b1 || redirect_valid !== 1'b0 || depth !== 3'd1 || stk_push !== 1'b0) begin
            n_fail++; $display("FAIL if_settle got done=%b redir=%b depth=%0d push=%b want 1 0 1 0", instr_done, redirect_valid, depth, stk_push);
        end
        @(posedge clk); #1;
        n_tests++;
        if (instr_ready !== 1'b1 || instr_done !== 1'b0) begin
            n_fail++; $display("FAIL if_ready_t3 got ready=%b done=%b want 1 0", instr_ready, instr_done);
        end
        flush("if_basic");
    endtask

    task automatic test_redirect();
        apply_reset();
        issue(2'b01, 4'b0000, 8'h20, 4'b1111, 1'b1);
        issue(2'b10, 4'b1111, 8'h30, 4'b1111, 1'b1);
        issue(2'b11, 4'b1111, 8'h40, 4'b1111, 1'b1);
        issue(2'b00, 4'b1111, 8'h50, 4'b1111, 1'b1);
        issue(2'b10, 4'b1111, 8'h60, 4'b1111, 1'b1);
        flush("redirect");
    endtask

    task automatic test_nest();
        apply_reset();
        issue(2'b01, 4'b0011, 8'h11, 4'b1111, 1'b0);
        issue(2'b10, 4'b0000, 8'h22, 4'b0011, 1'b0);
        issue(2'b11, 4'b0000, 8'h33, 4'b1100, 1'b0);
        flush("nest");
        n_tests++;
        if ({depth, err_overflow, err_underflow} !== 5'b0) begin
            n_fail++; $display("FAIL nest_end got %b want 00000", {depth, err_overflow, err_underflow});
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int i = 0; i < 8; i++) issue(2'b01, 4'b1111, 8'(i), 4'b1111, 1'b0);
        flush("overflow");
        n_tests++;
        if (depth !== 3'd7 || err_overflow !== 1'b1 || err_underflow !== 1'b0) begin
            n_fail++; $display("FAIL overflow_end got depth=%0d ovf=%b udf=%b want 7 1 0", depth, err_overflow, err_underflow);
        end
    endtask

    task automatic test_underflow();
        apply_reset();
        issue(2'b11, 4'b1111, 8'h70, 4'b1111, 1'b1);
        issue(2'b10, 4'b1111, 8'h71, 4'b1111, 1'b1);
        issue(2'b01, 4'b1010, 8'h72, 4'b1100, 1'b0);
        flush("underflow");
        n_tests++;
        if (depth !== 3'd1 || err_underflow !== 1'b1 || err_overflow !== 1'b0) begin
            n_fail++; $display("FAIL underflow_end got depth=%0d udf=%b ovf=%b want 1 1 0", depth, err_underflow, err_overflow);
        end
    endtask

    task automatic test_reset_abort();
        apply_reset();
        issue(2'b01, 4'b1111, 8'h80, 4'b1111, 1'b1);
        flush("abort_pre");
        @(negedge clk);
        instr_valid = 1'b1; instr_op = 2'b01; cond = 4'b1111; target_pc = 8'h81;
        @(negedge clk);
        instr_valid = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        n_tests++;
        if (depth !== 3'd0 || instr_ready !== 1'b1 || instr_done !== 1'b0) begin
            n_fail++; $display("FAIL abort_after got depth=%0d ready=%b done=%b want 0 1 0", depth, instr_ready, instr_done);
        end
        @(negedge clk);
        n_tests++;
        if (instr_done !== 1'b0 || redirect_valid !== 1'b0) begin
            n_fail++; $display("FAIL abort_no_pulse got done=%b redir=%b want 0 0", instr_done, redirect_valid);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int i = 0; i < 24; i++) begin
            issue(2'($urandom_range(0, 3)), 4'($urandom), 8'($urandom), 4'($urandom), 1'($urandom));
        end
        flush("back_to_back");
    endtask

    initial begin
        fork
            scoreboard_monitor();
        join_none
        test_reset();
        test_if_basic();
        test_redirect();
        test_nest();
        test_overflow();
        test_underflow();
        test_reset_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
